// File: rtl/riscv_pkg.sv
// Shared RISC-V constants: opcodes, instruction length rule and field-slice widths.
package riscv_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned HW_W      = 16;
    localparam int unsigned OPCODE_W  = 7;
    localparam int unsigned FUNCT3_W  = 3;
    localparam int unsigned FUNCT7_W  = 7;
    localparam int unsigned BUF_DEPTH = 4;
    localparam int unsigned BUF_CNT_W = 3;

    localparam logic [OPCODE_W-1:0] OPC_LOAD   = 7'h03;
    localparam logic [OPCODE_W-1:0] OPC_OP_IMM = 7'h13;
    localparam logic [OPCODE_W-1:0] OPC_AUIPC  = 7'h17;
    localparam logic [OPCODE_W-1:0] OPC_STORE  = 7'h23;
    localparam logic [OPCODE_W-1:0] OPC_OP     = 7'h33;
    localparam logic [OPCODE_W-1:0] OPC_LUI    = 7'h37;
    localparam logic [OPCODE_W-1:0] OPC_BRANCH = 7'h63;
    localparam logic [OPCODE_W-1:0] OPC_JALR   = 7'h67;
    localparam logic [OPCODE_W-1:0] OPC_JAL    = 7'h6F;
    localparam logic [OPCODE_W-1:0] OPC_SYSTEM = 7'h73;

    // Low two bits of 2'b11 mark a 32-bit instruction; anything else is compressed.
    localparam logic [1:0] LEN32_MARK = 2'b11;

    function automatic logic is_rvc(input logic [1:0] low_bits);
        return low_bits != LEN32_MARK;
    endfunction

endpackage

// File: rtl/ifetch_buf.sv
// Four-halfword align buffer: pop 0/1/2 from the head, append 0/1/2 at the tail, flush.
module ifetch_buf
    import riscv_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic [1:0]        pop_n,
    input  logic [1:0]        push_n,
    input  logic [XLEN-1:0]   push_data,
    output logic [HW_W-1:0]   head0_c,
    output logic [HW_W-1:0]   head1_c,
    output logic [BUF_CNT_W-1:0] cnt_c
);

    logic [BUF_DEPTH-1:0][HW_W-1:0] buf_q, buf_d, shf;
    logic [BUF_CNT_W-1:0] cnt_q, cnt_d, keep, rel;
    logic [HW_W-1:0]      push_lo;

    always_comb begin
        shf     = '0;
        buf_d   = '0;
        rel     = '0;
        keep    = cnt_q - BUF_CNT_W'(pop_n);
        // A single-halfword push is the high half of a word (redirect to pc[1]=1).
        push_lo = (push_n == 2'd1) ? push_data[31:16] : push_data[15:0];
        for (int i = 0; i < int'(BUF_DEPTH); i++) begin
            if (i + int'(pop_n) < int'(BUF_DEPTH)) begin
                shf[i] = buf_q[2'(i + int'(pop_n))];
            end
        end
        for (int i = 0; i < int'(BUF_DEPTH); i++) begin
            buf_d[i] = shf[i];
            if (BUF_CNT_W'(i) >= keep) begin
                rel = BUF_CNT_W'(i) - keep;
                if (rel < BUF_CNT_W'(push_n)) begin
                    buf_d[i] = (rel == '0) ? push_lo : push_data[31:16];
                end
            end
        end
        cnt_d = flush ? '0 : keep + BUF_CNT_W'(push_n);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q <= '0;
            cnt_q <= '0;
        end else begin
            buf_q <= buf_d;
            cnt_q <= cnt_d;
        end
    end

    assign head0_c = buf_d[0];
    assign head1_c = buf_d[1];
    assign cnt_c   = cnt_d;

endmodule

// File: rtl/ifetch_align.sv
// Instruction fetch front end: issues word fetches, drops stale responses after a redirect,
// and presents aligned 16/32-bit instructions to decode.
module ifetch_align
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [XLEN-1:0]     imem_addr,
    input  logic                imem_rsp_valid,
    input  logic [XLEN-1:0]     imem_rsp_data,
    input  logic                redirect_valid,
    input  logic [XLEN-1:0]     redirect_pc,
    output logic                instr_valid,
    input  logic                instr_ready,
    output logic [XLEN-1:0]     instr,
    output logic [XLEN-1:0]     instr_pc,
    output logic                instr_is16,
    output logic [OPCODE_W-1:0] opcode,
    output logic [FUNCT3_W-1:0] funct3,
    output logic [FUNCT7_W-1:0] funct7
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic                 req_valid_q, req_valid_d;
    logic [XLEN-1:0]      addr_q, addr_d;
    logic [CNT_W-1:0]     out_q, out_d;
    logic [CNT_W-1:0]     drop_q, drop_d;
    logic                 skip_q, skip_d;
    logic [XLEN-1:0]      pc_q, pc_d;
    logic                 instr_valid_q, instr_valid_d;
    logic [XLEN-1:0]      instr_q, instr_d;
    logic                 is16_q, is16_d;

    logic                 req_fire, kept_rsp, dec_fire, complete;
    logic [1:0]           pop_n, push_n;
    logic [HW_W-1:0]      head0_c, head1_c;
    logic [BUF_CNT_W-1:0] cnt_c;

    ifetch_buf u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .pop_n     (pop_n),
        .push_n    (push_n),
        .push_data (imem_rsp_data),
        .head0_c   (head0_c),
        .head1_c   (head1_c),
        .cnt_c     (cnt_c)
    );

    // Handshakes; a redirect kills both the decode handshake and any response this cycle.
    always_comb begin
        req_fire = req_valid_q && imem_req_ready;
        kept_rsp = imem_rsp_valid && (drop_q == '0) && !redirect_valid;
        dec_fire = instr_valid_q && instr_ready && !redirect_valid;
        pop_n    = dec_fire ? (is16_q ? 2'd1 : 2'd2) : 2'd0;
        push_n   = kept_rsp ? (skip_q ? 2'd1 : 2'd2) : 2'd0;
    end

    // Request, outstanding and drop bookkeeping.
    always_comb begin
        out_d  = out_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
        drop_d = drop_q;
        skip_d = skip_q;
        addr_d = addr_q;
        pc_d   = pc_q + XLEN'({pop_n, 1'b0});
        if (req_fire) begin
            addr_d = addr_q + XLEN'(4);
        end
        if (kept_rsp) begin
            skip_d = 1'b0;
        end
        if (imem_rsp_valid && (drop_q != '0)) begin
            drop_d = drop_q - CNT_W'(1);
        end
        if (redirect_valid) begin
            drop_d = out_d;
            skip_d = redirect_pc[1];
            addr_d = redirect_pc & ~XLEN'(3);
            pc_d   = redirect_pc & ~XLEN'(1);
        end
        // Reserve room for every in-flight word plus the one about to be requested.
        req_valid_d = (32'(cnt_c) + (32'(out_d) << 1) + 32'd2 <= 32'(BUF_DEPTH))
                      && (32'(out_d) < MAX_OUTSTANDING);
    end

    // Decode-facing outputs are registered from the buffer's next state.
    always_comb begin
        complete      = (cnt_c >= BUF_CNT_W'(2))
                        || ((cnt_c == BUF_CNT_W'(1)) && is_rvc(head0_c[1:0]));
        instr_valid_d = complete;
        is16_d        = complete && is_rvc(head0_c[1:0]);
        instr_d       = '0;
        if (complete) begin
            instr_d = is_rvc(head0_c[1:0]) ? {16'h0000, head0_c} : {head1_c, head0_c};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_valid_q   <= 1'b0;
            addr_q        <= RESET_PC;
            out_q         <= '0;
            drop_q        <= '0;
            skip_q        <= 1'b0;
            pc_q          <= RESET_PC;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            is16_q        <= 1'b0;
        end else begin
            req_valid_q   <= req_valid_d;
            addr_q        <= addr_d;
            out_q         <= out_d;
            drop_q        <= drop_d;
            skip_q        <= skip_d;
            pc_q          <= pc_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            is16_q        <= is16_d;
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_addr      = addr_q;
    assign instr_valid    = instr_valid_q;
    assign instr          = instr_q;
    assign instr_pc       = pc_q;
    assign instr_is16     = is16_q;
    assign opcode         = instr_q[6:0];
    assign funct3         = instr_q[14:12];
    assign funct7         = instr_q[31:25];

endmodule

// File: tb/tb_ifetch_align.sv
// Scoreboard bench for ifetch_align: a memory model answers fetches and an instruction-stream
// model, walked straight from the memory image, predicts what decode must see.
module tb_ifetch_align;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          MAX_OUT  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid, instr_ready;
    logic [31:0] instr, instr_pc;
    logic        instr_is16;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;

    ifetch_align #(.RESET_PC(RESET_PC), .MAX_OUTSTANDING(MAX_OUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
        .instr_is16(instr_is16), .opcode(opcode), .funct3(funct3), .funct7(funct7)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic [31:0] ins; logic is16; } ent_t;
    typedef struct { logic [31:0] addr; int cyc; } pend_t;

    logic [31:0] mem [256];
    ent_t  exp_q[$];
    ent_t  log_q[$];
    pend_t pend[$];

    int n_chk = 0, n_pass = 0;
    int cyc = 0, n_rsp = 0, n_acc = 0;
    int req_pct = 100, rsp_pct = 100, rdy_pct = 100;
    logic [31:0] mpc, exp_addr, last_acc_addr;
    logic        hold_i = 1'b0, hold_r = 1'b0;
    logic [31:0] snap_instr, snap_pc, snap_addr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [15:0] hw_at(input logic [31:0] a);
        logic [31:0] w;
        w = mem[a[9:2]];
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    // Walk the program image from mpc: 2'b11 in the low bits means a 32-bit instruction.
    task automatic gen_one();
        logic [15:0] h;
        ent_t e;
        h = hw_at(mpc);
        e.pc = mpc;
        if (h[1:0] != 2'b11) begin
            e.ins = {16'h0000, h}; e.is16 = 1'b1; mpc = mpc + 32'd2;
        end else begin
            e.ins = {hw_at(mpc + 32'd2), h}; e.is16 = 1'b0; mpc = mpc + 32'd4;
        end
        exp_q.push_back(e);
    endtask

    task automatic fill_random();
        logic [31:0] w;
        for (int i = 0; i < 256; i++) begin
            w = $urandom;
            if ($urandom_range(1) == 1) w[1:0] = 2'b11;
            if ($urandom_range(1) == 1) w[17:16] = 2'b11;
            mem[i] = w;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_fields", {15'd0, opcode, funct3, funct7}, 32'd0);
        chk("rst_is16", 32'(instr_is16), 32'd0);
        chk("rst_instr_pc", instr_pc, RESET_PC);
        chk("rst_imem_addr", imem_addr, RESET_PC);
        pend.delete(); exp_q.delete(); log_q.delete();
        mpc = RESET_PC; exp_addr = RESET_PC; hold_i = 1'b0; hold_r = 1'b0; n_rsp = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("req_after_rst", 32'(imem_req_valid), 32'd1);
        while (exp_q.size() < 8) gen_one();
    endtask

    // One clock of stimulus: memory acceptance/response, decode ready, optional redirect.
    task automatic step(input logic redir, input logic [31:0] rpc);
        @(posedge clk); #1;
        cyc++;
        if (hold_i) begin
            chk("hold_valid", 32'(instr_valid), 32'd1);
            chk("hold_instr", instr, snap_instr);
            chk("hold_pc", instr_pc, snap_pc);
        end
        if (hold_r) begin
            chk("hold_req_valid", 32'(imem_req_valid), 32'd1);
            chk("hold_req_addr", imem_addr, snap_addr);
        end
        imem_req_ready = ($urandom_range(99) < req_pct);
        instr_ready    = ($urandom_range(99) < rdy_pct);
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        if (imem_req_valid && imem_req_ready) begin
            chk("req_addr", imem_addr, exp_addr);
            chk("outstanding_lt_max", 32'(pend.size() < MAX_OUT), 32'd1);
            pend.push_back('{addr: imem_addr, cyc: cyc});
            last_acc_addr = imem_addr;
            exp_addr = exp_addr + 32'd4;
            n_acc++;
        end
        if (pend.size() > 0 && pend[0].cyc < cyc && $urandom_range(99) < rsp_pct) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem[pend[0].addr[9:2]];
            void'(pend.pop_front());
            n_rsp++;
        end
        if (redir) begin
            exp_q.delete();
            mpc      = rpc & ~32'd1;
            exp_addr = rpc & ~32'd3;
        end
        while (exp_q.size() < 8) gen_one();
        hold_i = instr_valid && !instr_ready && !redirect_valid;
        hold_r = imem_req_valid && !imem_req_ready && !redirect_valid;
        snap_instr = instr; snap_pc = instr_pc; snap_addr = imem_addr;
    endtask

    task automatic wait_log(input int n, input int budget);
        int b;
        b = budget;
        while (log_q.size() < n && b > 0) begin
            step(1'b0, 32'd0);
            b--;
        end
        chk("log_timeout", 32'(log_q.size() >= n), 32'd1);
    endtask

    task automatic chk_ent(input int idx, input logic [31:0] pc, input logic [31:0] ins,
                           input logic is16);
        if (log_q.size() > idx) begin
            chk("dir_pc", log_q[idx].pc, pc);
            chk("dir_instr", log_q[idx].ins, ins);
            chk("dir_is16", 32'(log_q[idx].is16), 32'(is16));
        end
    endtask

    // Monitor: every decode handshake is popped from the scoreboard and compared.
    always @(negedge clk) begin
        ent_t e, got;
        if (rst_n && instr_valid && instr_ready && !redirect_valid) begin
            got.pc = instr_pc; got.ins = instr; got.is16 = instr_is16;
            log_q.push_back(got);
            if (exp_q.size() == 0) begin
                chk("exp_empty", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("mon_pc", instr_pc, e.pc);
                chk("mon_instr", instr, e.ins);
                chk("mon_is16", 32'(instr_is16), 32'(e.is16));
                chk("mon_fields", {15'd0, opcode, funct3, funct7},
                    {15'd0, e.ins[6:0], e.ins[14:12], e.ins[31:25]});
            end
        end
    end

    initial begin
        int b;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

        // Two 32-bit instructions; first one appears the cycle after its response.
        fill_random();
        mem[0] = 32'h0051_0113; mem[1] = 32'h0000_0013;
        req_pct = 100; rsp_pct = 100; rdy_pct = 100;
        do_reset();
        b = 20;
        while (n_rsp == 0 && b > 0) begin step(1'b0, 32'd0); b--; end
        chk("first_rsp_seen", 32'(n_rsp > 0), 32'd1);
        step(1'b0, 32'd0);
        chk("lat1_valid", 32'(instr_valid), 32'd1);
        chk("lat1_instr", instr, 32'h0051_0113);
        chk("lat1_opcode", 32'(opcode), 32'h13);
        chk("lat1_funct3", 32'(funct3), 32'd0);
        wait_log(2, 40);
        chk_ent(0, 32'h0, 32'h0051_0113, 1'b0);
        chk_ent(1, 32'h4, 32'h0000_0013, 1'b0);

        // Two compressed instructions in one word.
        fill_random();
        mem[0] = 32'h4505_0001;
        do_reset();
        wait_log(2, 40);
        chk_ent(0, 32'h0, 32'h0000_0001, 1'b1);
        chk_ent(1, 32'h2, 32'h0000_4505, 1'b1);

        // 32-bit instruction straddling a word boundary.
        fill_random();
        mem[0] = 32'h0113_0001; mem[1] = 32'h0000_0051;
        do_reset();
        wait_log(2, 40);
        chk_ent(0, 32'h0, 32'h0000_0001, 1'b1);
        chk_ent(1, 32'h2, 32'h0051_0113, 1'b0);

        // Decode stalled for 10 cycles.
        fill_random();
        do_reset();
        rdy_pct = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 32'd0);
            chk("occ_le4", 32'(dut.u_buf.cnt_q <= 3'd4), 32'd1);
        end
        chk("stall_valid", 32'(instr_valid), 32'd1);
        rdy_pct = 100;
        wait_log(4, 60);

        // Redirect to 0x102 with two fetches in flight.
        fill_random();
        mem[64] = 32'h4505_1234;
        rsp_pct = 0; rdy_pct = 0;
        do_reset();
        b = 10;
        while (pend.size() < 2 && b > 0) begin step(1'b0, 32'd0); b--; end
        chk("two_in_flight", 32'(pend.size()), 32'd2);
        step(1'b1, 32'h0000_0102);
        rsp_pct = 100; rdy_pct = 100;
        b = n_acc;
        for (int i = 0; i < 20 && n_acc == b; i++) step(1'b0, 32'd0);
        chk("redir_addr", last_acc_addr, 32'h0000_0100);
        wait_log(2, 40);
        chk_ent(0, 32'h102, 32'h0000_4505, 1'b1);

        // Random traffic with redirects, back-to-back redirects and a mid-stream reset.
        fill_random();
        req_pct = 70; rsp_pct = 70; rdy_pct = 70;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) begin
                do_reset();
            end else if (i == 100 || i == 101 || $urandom_range(99) < 2) begin
                step(1'b1, $urandom & 32'h0000_03FE);
            end else begin
                step(1'b0, 32'd0);
            end
        end
        chk("random_progress", 32'(log_q.size() > 50), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
